// File: rtl/xbar_l2_pkg.sv
// Shared types for the L2 crossbar bank arbiter.
//   N_MASTERS, DATA_W : default configuration constants
//   master_id_t       : master index, sized for the default N_MASTERS
//   resp_slot_t       : one response-pipe stage {valid, master id}
package xbar_l2_pkg;

  localparam int unsigned N_MASTERS = 9;
  localparam int unsigned DATA_W    = 32;

  typedef logic [$clog2(N_MASTERS)-1:0] master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t id;
  } resp_slot_t;

endpackage

// File: rtl/xbar_rr_arb.sv
// Round-robin arbiter holding the rotating priority pointer.
//   clk, rst   : clock, asynchronous active-high reset
//   req_i      : per-master request vector
//   gnt_o      : one-hot grant (zero when nothing requests)
//   winner_o   : index of the granted master (0 when nothing requests)
//   valid_o    : a grant was issued this cycle
module xbar_rr_arb #(
  parameter int unsigned N_MASTERS = 9,
  localparam int unsigned ID_W     = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic [ID_W-1:0]      winner_o,
  output logic                 valid_o
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int unsigned idx;
    gnt_o    = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    rr_ptr_d = rr_ptr_q;
    // Scan starting at the pointer, wrapping modulo N_MASTERS.
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = ID_W'(idx);
      end
    end
    if (valid_o) begin
      gnt_o[winner_o] = 1'b1;
      rr_ptr_d = (winner_o == ID_W'(N_MASTERS - 1)) ? '0 : winner_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/xbar_l2_bank_arbiter.sv
// Per-bank round-robin arbiter: shares one single-port L2 SRAM bank among
// N_MASTERS masters, forwards the winner's command and routes the response
// back RESP_LAT cycles later.
//   req_i/add_i/wen_i/wdata_i/be_i : per-master command (wen 1 = load)
//   gnt_o                          : same-cycle one-hot grant
//   r_valid_o/r_rdata_o            : per-master response (rdata 0 for stores)
//   mem_*_o / mem_rdata_i          : bank macro interface
// Optional: define XBAR_ARB_STATS_EN to add stat_clr_i / stat_gnt_cnt_o
// (saturating 32-bit grant counter per master, clear wins over increment).
// N_MASTERS must fit in xbar_l2_pkg::master_id_t.
module xbar_l2_bank_arbiter
  import xbar_l2_pkg::*;
#(
  parameter int unsigned N_MASTERS = xbar_l2_pkg::N_MASTERS,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned BANK_W    = 4,
  parameter int unsigned DATA_W    = xbar_l2_pkg::DATA_W,
  parameter int unsigned RESP_LAT  = 1,
  localparam int unsigned ROW_W    = ADDR_W - BANK_W,
  localparam int unsigned BE_W     = DATA_W / 8,
  localparam int unsigned ID_W     = $clog2(N_MASTERS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        req_i,
  input  logic [N_MASTERS*ADDR_W-1:0] add_i,
  input  logic [N_MASTERS-1:0]        wen_i,
  input  logic [N_MASTERS*DATA_W-1:0] wdata_i,
  input  logic [N_MASTERS*BE_W-1:0]   be_i,
  output logic [N_MASTERS-1:0]        gnt_o,
  output logic [N_MASTERS-1:0]        r_valid_o,
  output logic [N_MASTERS*DATA_W-1:0] r_rdata_o,
  output logic                        mem_req_o,
  output logic [ROW_W-1:0]            mem_add_o,
  output logic                        mem_wen_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  output logic [BE_W-1:0]             mem_be_o,
`ifdef XBAR_ARB_STATS_EN
  input  logic                        stat_clr_i,
  output logic [N_MASTERS*32-1:0]     stat_gnt_cnt_o,
`endif
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  logic [ID_W-1:0] winner;
  logic            any_gnt;

  xbar_rr_arb #(.N_MASTERS(N_MASTERS)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .winner_o (winner),
    .valid_o  (any_gnt)
  );

  // Command mux: bank sees zeros when idle.
  always_comb begin
    mem_req_o   = any_gnt;
    mem_add_o   = '0;
    mem_wen_o   = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (any_gnt) begin
      mem_add_o   = add_i[int'(winner)*ADDR_W + BANK_W +: ROW_W];
      mem_wen_o   = wen_i[winner];
      mem_wdata_o = wdata_i[int'(winner)*DATA_W +: DATA_W];
      mem_be_o    = be_i[int'(winner)*BE_W +: BE_W];
    end
  end

  // Response pipe; a parallel load flag lets stores return zero data.
  resp_slot_t                pipe_q [RESP_LAT];
  logic       [RESP_LAT-1:0] load_q;
  resp_slot_t                slot_d;
  resp_slot_t                tail;

  always_comb begin
    slot_d       = '0;
    slot_d.valid = any_gnt;
    slot_d.id    = master_id_t'(winner);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RESP_LAT; i++) pipe_q[i] <= '0;
      load_q <= '0;
    end else begin
      pipe_q[0] <= slot_d;
      load_q[0] <= any_gnt & mem_wen_o;
      for (int unsigned i = 1; i < RESP_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
        load_q[i] <= load_q[i-1];
      end
    end
  end

  always_comb begin
    tail      = pipe_q[RESP_LAT-1];
    r_valid_o = '0;
    r_rdata_o = '0;
    if (tail.valid) begin
      r_valid_o[tail.id] = 1'b1;
      if (load_q[RESP_LAT-1]) r_rdata_o[int'(tail.id)*DATA_W +: DATA_W] = mem_rdata_i;
    end
  end

`ifdef XBAR_ARB_STATS_EN
  logic [31:0] cnt_q [N_MASTERS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_MASTERS; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        if (stat_clr_i)                    cnt_q[i] <= '0;
        else if (gnt_o[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_gnt_cnt_o = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) stat_gnt_cnt_o[i*32 +: 32] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_xbar_l2_bank_arbiter.sv
module tb_xbar_l2_bank_arbiter;
  localparam int N = 9, AW = 14, BW = 4, DW = 32, BEW = 4, RW = AW - BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req, wen;
  logic [N*AW-1:0] add;
  logic [N*DW-1:0] wdata;
  logic [N*BEW-1:0] be;
  logic [DW-1:0]   rdata_mem;

  logic [N-1:0]    gnt1, rv1, gnt3, rv3;
  logic [N*DW-1:0] rd1, rd3;
  logic            mreq1, mwen1, mreq3, mwen3;
  logic [RW-1:0]   madd1, madd3;
  logic [DW-1:0]   mwd1, mwd3;
  logic [BEW-1:0]  mbe1, mbe3;
`ifdef XBAR_ARB_STATS_EN
  logic            stat_clr;
  logic [N*32-1:0] stat1, stat3;
  int unsigned     cnt_m [N];
`endif

  xbar_l2_bank_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .BANK_W(BW), .DATA_W(DW), .RESP_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt1), .r_valid_o(rv1), .r_rdata_o(rd1), .mem_req_o(mreq1), .mem_add_o(madd1),
    .mem_wen_o(mwen1), .mem_wdata_o(mwd1), .mem_be_o(mbe1),
`ifdef XBAR_ARB_STATS_EN
    .stat_clr_i(stat_clr), .stat_gnt_cnt_o(stat1),
`endif
    .mem_rdata_i(rdata_mem));

  xbar_l2_bank_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .BANK_W(BW), .DATA_W(DW), .RESP_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt3), .r_valid_o(rv3), .r_rdata_o(rd3), .mem_req_o(mreq3), .mem_add_o(madd3),
    .mem_wen_o(mwen3), .mem_wdata_o(mwd3), .mem_be_o(mbe3),
`ifdef XBAR_ARB_STATS_EN
    .stat_clr_i(stat_clr), .stat_gnt_cnt_o(stat3),
`endif
    .mem_rdata_i(rdata_mem));

  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: pointer as an integer, in-flight responses as queues
  // whose length equals the bank latency.
  typedef struct { bit v; int id; bit ld; } rs_t;
  int  ptr;
  int  cur_win;
  rs_t q1[$], q3[$];

  function automatic void reset_model();
    rs_t e;
    e.v = 0; e.id = 0; e.ld = 0;
    ptr = 0;
    q1 = {};
    q3 = {};
    q1.push_back(e);
    for (int i = 0; i < 3; i++) q3.push_back(e);
`ifdef XBAR_ARB_STATS_EN
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
`endif
  endfunction

  function automatic int model_win();
    for (int k = 0; k < N; k++) begin
      int m;
      m = (ptr + k) % N;
      if (req[m]) return m;
    end
    return -1;
  endfunction

  function automatic logic [N*DW-1:0] exp_rd(input rs_t e);
    logic [N*DW-1:0] r;
    r = '0;
    if (e.v && e.ld) r[e.id*DW +: DW] = rdata_mem;
    return r;
  endfunction

  function automatic logic [N-1:0] exp_rv(input rs_t e);
    logic [N-1:0] r;
    r = '0;
    if (e.v) r[e.id] = 1'b1;
    return r;
  endfunction

  // Called just after a falling edge with inputs already applied.
  task automatic drive_check();
    logic [N-1:0] eg;
    rdata_mem = $urandom;
    #2;
    if (rst) reset_model();
    cur_win = model_win();
    eg = '0;
    if (cur_win >= 0) eg[cur_win] = 1'b1;
    chk("gnt", gnt1, eg);
    chk("gnt_lat3", gnt3, eg);
    chk("mem_req", mreq1, cur_win >= 0);
    if (cur_win >= 0) begin
      chk("mem_add", madd1, add[cur_win*AW + BW +: RW]);
      chk("mem_wen", mwen1, wen[cur_win]);
      chk("mem_wdata", mwd1, wdata[cur_win*DW +: DW]);
      chk("mem_be", mbe1, be[cur_win*BEW +: BEW]);
    end else begin
      chk("mem_idle", {madd1, mwen1, mwd1, mbe1}, '0);
    end
    chk("r_valid", rv1, exp_rv(q1[0]));
    chk("r_rdata", rd1, exp_rd(q1[0]));
    chk("r_valid_lat3", rv3, exp_rv(q3[0]));
    chk("r_rdata_lat3", rd3, exp_rd(q3[0]));
`ifdef XBAR_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      chk("stat_cnt", stat1[i*32 +: 32], cnt_m[i]);
      chk("stat_cnt_lat3", stat3[i*32 +: 32], cnt_m[i]);
    end
`endif
  endtask

  task automatic advance();
    rs_t e;
    @(posedge clk);
    if (rst) begin
      reset_model();
    end else begin
      e.v = (cur_win >= 0);
      e.id = (cur_win >= 0) ? cur_win : 0;
      e.ld = (cur_win >= 0) ? wen[cur_win] : 1'b0;
      void'(q1.pop_front());
      void'(q3.pop_front());
      q1.push_back(e);
      q3.push_back(e);
`ifdef XBAR_ARB_STATS_EN
      if (stat_clr) for (int i = 0; i < N; i++) cnt_m[i] = 0;
      else if (cur_win >= 0 && cnt_m[cur_win] != 32'hFFFF_FFFF) cnt_m[cur_win]++;
`endif
      if (cur_win >= 0) ptr = (cur_win + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    drive_check();
    advance();
    rst = 1'b0;
  endtask

  typedef struct { logic [N-1:0] req; logic [N-1:0] gnt; } vec_t;
  vec_t tbl [16];

  initial begin
    logic [N*DW-1:0] lane;
    rst = 1'b1; req = '0; wen = '0; add = '0; wdata = '0; be = '0; rdata_mem = '0;
`ifdef XBAR_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    reset_model();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    drive_check();
    chk("rst_gnt", gnt1, '0);
    chk("rst_rvalid", rv1, '0);
    advance();

    // Single load on master 3.
    req = 9'h008;
    wen[3] = 1'b1;
    add[3*AW +: AW] = 14'h0153;
    drive_check();
    chk("t1_gnt", gnt1, 9'h008);
    chk("t1_add", madd1, 10'h015);
    advance();
    req = '0;
    drive_check();
    lane = '0;
    lane[3*DW +: DW] = rdata_mem;
    chk("t1_rvalid", rv1, 9'h008);
    chk("t1_rdata", rd1, lane);
    advance();

    // Full rotation with wrap, then 2/7 alternation from pointer 3.
    for (int i = 0; i < 12; i++) begin
      tbl[i].req = 9'h1FF;
      tbl[i].gnt = 9'(1 << (i % N));
    end
    tbl[12].req = 9'h084; tbl[12].gnt = 9'h080;
    tbl[13].req = 9'h084; tbl[13].gnt = 9'h004;
    tbl[14].req = 9'h084; tbl[14].gnt = 9'h080;
    tbl[15].req = 9'h084; tbl[15].gnt = 9'h004;
    do_reset();
    wen = '1;
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req;
      drive_check();
      chk("tbl_gnt", gnt1, tbl[i].gnt);
      advance();
    end
    req = '0;
    for (int i = 0; i < 3; i++) begin drive_check(); advance(); end

    // Back-to-back stores on masters 1 and 5 through the 3-cycle bank.
    do_reset();
    wen = '0;
    req = 9'h002; drive_check(); advance();
    req = 9'h020; drive_check(); advance();
    req = '0;     drive_check(); advance();
    drive_check();
    chk("t4_rvalid_m1", rv3, 9'h002);
    chk("t4_rdata_m1", rd3, '0);
    advance();
    drive_check();
    chk("t4_rvalid_m5", rv3, 9'h020);
    chk("t4_rdata_m5", rd3, '0);
    advance();

    // Reset while a load to master 4 is in flight.
    do_reset();
    wen = '1;
    req = 9'h010; drive_check(); advance();
    req = '0;
    rst = 1'b1;
    drive_check();
    chk("t5_rvalid_in_rst", rv1, '0);
    advance();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_check();
      chk("t5_no_rvalid", rv1 | rv3, '0);
      advance();
    end
    req = 9'h1FF;
    drive_check();
    chk("t5_gnt0", gnt1, 9'h001);
    advance();

`ifdef XBAR_ARB_STATS_EN
    // Counter clear wins over a simultaneous grant.
    do_reset();
    req = 9'h001;
    for (int i = 0; i < 5; i++) begin drive_check(); advance(); end
    chk("t6_cnt5", stat1[31:0], 32'd5);
    stat_clr = 1'b1;
    drive_check();
    advance();
    stat_clr = 1'b0;
    req = '0;
    drive_check();
    chk("t6_cnt_clr", stat1[31:0], 32'd0);
    advance();
`endif

    // Randomized traffic; masters hold their command until granted.
    do_reset();
    req = '0;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < N; m++) begin
        if (!req[m] && ($urandom_range(2) == 0)) begin
          req[m] = 1'b1;
          wen[m] = 1'($urandom);
          add[m*AW +: AW] = AW'($urandom);
          wdata[m*DW +: DW] = $urandom;
          be[m*BEW +: BEW] = BEW'($urandom);
        end
      end
      drive_check();
      advance();
      if (cur_win >= 0) req[cur_win] = 1'b0;
    end
    req = '0;
    for (int i = 0; i < 4; i++) begin drive_check(); advance(); end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
